// File: rtl/data_memory_stage.sv
// -----------------------------------------------------------------------------
// data_memory_stage
//
// Memory-access pipeline stage that sits directly in front of write-back.
// It takes the execute-stage result and either passes it straight through,
// stores b_ex into a small register-file RAM, or loads a word from that RAM.
// The chosen value is registered as mux_ans_dm together with the destination
// tag and write-enable that travel with it. Latency is one clock.
//
// Ports:
//   clk        in   1       rising-edge stage clock
//   reset      in   1       synchronous active-high; clears outputs and RAM
//   valid_ex   in   1       execute-stage instruction valid
//   ans_ex     in   DATA_W  ALU result; low ADDR_W bits are the RAM address
//   b_ex       in   DATA_W  store data
//   mem_en_ex  in   1       instruction accesses memory
//   mem_wr_ex  in   1       1 = store, 0 = load (when mem_en_ex = 1)
//   rd_ex      in   RD_W    destination register tag
//   wb_en_ex   in   1       instruction writes the register file
//   stall      in   1       hold all state (reset still wins)
//   mux_ans_dm out  DATA_W  selected result to write-back
//   rd_dm      out  RD_W    destination tag to write-back
//   wb_en_dm   out  1       register write enable to write-back
//   valid_dm   out  1       output register holds a valid instruction
// -----------------------------------------------------------------------------
module data_memory_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ex,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] b_ex,
    input  logic              mem_en_ex,
    input  logic              mem_wr_ex,
    input  logic [RD_W-1:0]   rd_ex,
    input  logic              wb_en_ex,
    input  logic              stall,
    output logic [DATA_W-1:0] mux_ans_dm,
    output logic [RD_W-1:0]   rd_dm,
    output logic              wb_en_dm,
    output logic              valid_dm
);

    logic [DATA_W-1:0] r_ram [DEPTH];

    logic [DATA_W-1:0] r_mux_ans_p1;
    logic [RD_W-1:0]   r_rd_p1;
    logic              r_wb_en_p1;
    logic              vld_p1;

    // Upper address bits are dropped, so accesses wrap modulo DEPTH.
    logic [ADDR_W-1:0] w_addr;
    logic              w_store;
    logic              w_load;

    assign w_addr  = ans_ex[ADDR_W-1:0];
    assign w_store = valid_ex &  mem_en_ex &  mem_wr_ex;
    assign w_load  = valid_ex &  mem_en_ex & ~mem_wr_ex;

    // ---- execute -> memory/write-back boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            // The RAM is cleared too, so an in-flight store is discarded.
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= '0;
            end
            r_mux_ans_p1 <= '0;
            r_rd_p1      <= '0;
            r_wb_en_p1   <= 1'b0;
            vld_p1       <= 1'b0;
        end else if (!stall) begin
            r_rd_p1 <= rd_ex;
            vld_p1  <= valid_ex;
            if (w_store) begin
                r_ram[w_addr] <= b_ex;
                r_mux_ans_p1  <= ans_ex;
                r_wb_en_p1    <= 1'b0;
            end else if (w_load) begin
                // Reads the pre-edge contents; a store one cycle earlier is
                // already committed, so store->load forwarding is implicit.
                r_mux_ans_p1 <= r_ram[w_addr];
                r_wb_en_p1   <= wb_en_ex;
            end else if (valid_ex) begin
                r_mux_ans_p1 <= ans_ex;
                r_wb_en_p1   <= wb_en_ex;
            end else begin
                // Bubble: result keeps its last value, only enables drop.
                r_wb_en_p1 <= 1'b0;
            end
        end
    end

    assign mux_ans_dm = r_mux_ans_p1;
    assign rd_dm      = r_rd_p1;
    assign wb_en_dm   = r_wb_en_p1;
    assign valid_dm   = vld_p1;

endmodule

// File: tb/tb_data_memory_stage.sv
module tb_data_memory_stage;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int RD_W   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_ex;
    logic [DATA_W-1:0] ans_ex;
    logic [DATA_W-1:0] b_ex;
    logic              mem_en_ex;
    logic              mem_wr_ex;
    logic [RD_W-1:0]   rd_ex;
    logic              wb_en_ex;
    logic              stall;
    logic [DATA_W-1:0] mux_ans_dm;
    logic [RD_W-1:0]   rd_dm;
    logic              wb_en_dm;
    logic              valid_dm;

    data_memory_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_W(RD_W)
    ) dut (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .ans_ex(ans_ex),
        .b_ex(b_ex), .mem_en_ex(mem_en_ex), .mem_wr_ex(mem_wr_ex),
        .rd_ex(rd_ex), .wb_en_ex(wb_en_ex), .stall(stall),
        .mux_ans_dm(mux_ans_dm), .rd_dm(rd_dm), .wb_en_dm(wb_en_dm),
        .valid_dm(valid_dm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: memory as a plain array, outputs as plain variables.
    int m_mem [DEPTH];
    int m_mux, m_rd, m_wb, m_vld;

    // Apply one clock with the given inputs and advance the model by the
    // instruction-level rules; outputs are then sampled 1 ns after the edge.
    task automatic step(input bit v, input int ans, input int b, input bit en,
                        input bit wr, input int rd, input bit wbe,
                        input bit st, input bit rst);
        int a;
        valid_ex = v; ans_ex = ans[7:0]; b_ex = b[7:0]; mem_en_ex = en;
        mem_wr_ex = wr; rd_ex = rd[2:0]; wb_en_ex = wbe; stall = st; reset = rst;
        @(posedge clk);
        a = (ans & 255) % DEPTH;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            m_mux = 0; m_rd = 0; m_wb = 0; m_vld = 0;
        end else if (!st) begin
            if (v && en && wr) begin
                m_mem[a] = b & 255; m_mux = ans & 255; m_wb = 0;
            end else if (v && en) begin
                m_mux = m_mem[a]; m_wb = wbe;
            end else if (v) begin
                m_mux = ans & 255; m_wb = wbe;
            end else begin
                m_wb = 0;
            end
            m_rd = rd & 7; m_vld = v;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        step(1, 'h03, 'h55, 1, 1, 2, 1, 0, 1);
        step(1, 'h03, 'h55, 1, 1, 2, 1, 0, 1);
        total++;
        if ({mux_ans_dm, rd_dm, wb_en_dm, valid_dm} !== 13'd0) begin
            bad++; $display("FAIL reset_outputs: got mux=%h rd=%0d wb=%b v=%b want all zero",
                            mux_ans_dm, rd_dm, wb_en_dm, valid_dm);
        end
        step(1, 'h03, 0, 1, 0, 1, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'h00) begin
            bad++; $display("FAIL reset_ram3: got %h want 00", mux_ans_dm);
        end
    endtask

    task automatic test_store_load();
        step(1, 'h03, 'hA5, 1, 1, 4, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'h03 || wb_en_dm !== 1'b0) begin
            bad++; $display("FAIL store_edge: got mux=%h wb=%b want 03/0", mux_ans_dm, wb_en_dm);
        end
        step(1, 'h03, 0, 1, 0, 5, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'hA5 || wb_en_dm !== 1'b1 || rd_dm !== 3'd5 || valid_dm !== 1'b1) begin
            bad++; $display("FAIL load_edge: got mux=%h wb=%b rd=%0d v=%b want A5/1/5/1",
                            mux_ans_dm, wb_en_dm, rd_dm, valid_dm);
        end
    endtask

    task automatic test_alu();
        step(1, 'h0F, 'h99, 0, 1, 6, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'h0F || wb_en_dm !== 1'b1 || rd_dm !== 3'd6) begin
            bad++; $display("FAIL alu_0f: got mux=%h wb=%b rd=%0d want 0F/1/6", mux_ans_dm, wb_en_dm, rd_dm);
        end
        step(1, 'hFF, 0, 0, 0, 1, 0, 0, 0);
        total++;
        if (mux_ans_dm !== 8'hFF || wb_en_dm !== 1'b0) begin
            bad++; $display("FAIL alu_ff: got mux=%h wb=%b want FF/0", mux_ans_dm, wb_en_dm);
        end
    endtask

    task automatic test_wrap();
        step(1, 'h12, 'h3C, 1, 1, 0, 1, 0, 0);
        step(1, 'h02, 0, 1, 0, 2, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'h3C) begin
            bad++; $display("FAIL addr_wrap: got %h want 3C", mux_ans_dm);
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] s_mux;
        logic [RD_W-1:0]   s_rd;
        logic              s_wb, s_v;
        step(1, 'h21, 0, 0, 0, 3, 1, 0, 0);
        s_mux = mux_ans_dm; s_rd = rd_dm; s_wb = wb_en_dm; s_v = valid_dm;
        for (int c = 0; c < 3; c++) begin
            step(1, 'h09, 'h77, 1, 1, 7, 0, 1, 0);
            total++;
            if ({mux_ans_dm, rd_dm, wb_en_dm, valid_dm} !== {s_mux, s_rd, s_wb, s_v}) begin
                bad++; $display("FAIL stall_hold%0d: got mux=%h rd=%0d wb=%b v=%b want %h/%0d/%b/%b",
                                c, mux_ans_dm, rd_dm, wb_en_dm, valid_dm, s_mux, s_rd, s_wb, s_v);
            end
        end
        step(0, 'h44, 0, 0, 0, 2, 1, 1, 0);
        total++;
        if ({mux_ans_dm, rd_dm, wb_en_dm, valid_dm} !== {s_mux, s_rd, s_wb, s_v}) begin
            bad++; $display("FAIL stall_bubble_hold: got mux=%h v=%b want %h/%b", mux_ans_dm, valid_dm, s_mux, s_v);
        end
        step(1, 'h09, 0, 1, 0, 1, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'h00) begin
            bad++; $display("FAIL stall_no_write: got %h want 00", mux_ans_dm);
        end
        step(1, 'h09, 'h77, 1, 1, 7, 0, 0, 0);
        step(1, 'h09, 0, 1, 0, 1, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'h77) begin
            bad++; $display("FAIL stall_release_write: got %h want 77", mux_ans_dm);
        end
    endtask

    task automatic test_bubble();
        logic [DATA_W-1:0] s_mux;
        logic [RD_W-1:0]   s_rd;
        step(1, 'h5A, 0, 0, 0, 4, 1, 0, 0);
        s_mux = mux_ans_dm; s_rd = rd_dm;
        step(0, 'hC3, 'h11, 1, 1, 6, 1, 0, 0);
        total++;
        if (wb_en_dm !== 1'b0 || valid_dm !== 1'b0 || mux_ans_dm !== s_mux) begin
            bad++; $display("FAIL bubble: got wb=%b v=%b mux=%h want 0/0/%h", wb_en_dm, valid_dm, mux_ans_dm, s_mux);
        end
        step(1, 'h03, 0, 1, 0, 2, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'hA5) begin
            bad++; $display("FAIL bubble_no_write: got %h want A5", mux_ans_dm);
        end
    endtask

    task automatic test_reset_stall();
        step(1, 'h33, 0, 0, 0, 5, 1, 0, 0);
        step(1, 'h09, 'h66, 1, 1, 5, 1, 1, 1);
        total++;
        if ({mux_ans_dm, rd_dm, wb_en_dm, valid_dm} !== 13'd0) begin
            bad++; $display("FAIL reset_with_stall: got mux=%h rd=%0d wb=%b v=%b want all zero",
                            mux_ans_dm, rd_dm, wb_en_dm, valid_dm);
        end
        step(1, 'h09, 0, 1, 0, 1, 1, 0, 0);
        total++;
        if (mux_ans_dm !== 8'h00) begin
            bad++; $display("FAIL reset_clears_ram: got %h want 00", mux_ans_dm);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);
            total++;
            if ({mux_ans_dm, rd_dm, wb_en_dm, valid_dm} !==
                {m_mux[7:0], m_rd[2:0], m_wb[0], m_vld[0]}) begin
                bad++; $display("FAIL random%0d: got mux=%h rd=%0d wb=%b v=%b want %h/%0d/%0d/%0d",
                                n, mux_ans_dm, rd_dm, wb_en_dm, valid_dm, m_mux, m_rd, m_wb, m_vld);
            end
        end
    endtask

    initial begin
        m_mux = 0; m_rd = 0; m_wb = 0; m_vld = 0;
        test_reset();
        test_store_load();
        test_alu();
        test_wrap();
        test_stall();
        test_bubble();
        test_reset_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
